// File: rtl/encap_arb_pkg.sv
// Shared constants and types for the encapsulation source arbiter.
// Holds the source index map, the arbiter state encoding, the default
// timing parameters and the beat/descriptor widths.
package encap_arb_pkg;

    // Source slots on the request/data/descriptor buses
    localparam int unsigned SRC_ARP  = 0;
    localparam int unsigned SRC_PTP  = 1;
    localparam int unsigned SRC_NMAC = 2;
    localparam int unsigned NUM_SRC  = 3;

    // Beat bit 8 marks SOF and EOF; descriptor is opaque to the arbiter
    localparam int unsigned BEAT_W = 9;
    localparam int unsigned DESC_W = 35;

    localparam int unsigned IFG_CYCLES_DEF    = 20;
    localparam int unsigned START_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StXfer,
        StGap
    } arb_state_e;

endpackage

// File: rtl/encap_arb_pick.sv
// Combinational source picker: PTP has strict priority, ARP and NMAC share
// via a 1-bit round-robin pointer that only matters when both request.
// Ports:
//   iv_req   - per-source request (0=ARP, 1=PTP, 2=NMAC)
//   i_rr_ptr - 0 favours ARP, 1 favours NMAC on an ARP/NMAC tie
//   ov_pick  - one-hot pick, all zero when nothing requests
module encap_arb_pick
    import encap_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] iv_req,
    input  logic               i_rr_ptr,
    output logic [NUM_SRC-1:0] ov_pick
);

    always_comb begin
        ov_pick = '0;
        if (iv_req[SRC_PTP]) begin
            ov_pick[SRC_PTP] = 1'b1;
        end else if (iv_req[SRC_ARP] && iv_req[SRC_NMAC]) begin
            if (i_rr_ptr) begin
                ov_pick[SRC_NMAC] = 1'b1;
            end else begin
                ov_pick[SRC_ARP] = 1'b1;
            end
        end else if (iv_req[SRC_ARP]) begin
            ov_pick[SRC_ARP] = 1'b1;
        end else if (iv_req[SRC_NMAC]) begin
            ov_pick[SRC_NMAC] = 1'b1;
        end
    end

endmodule

// File: rtl/encap_src_arbiter.sv
// Arbitrates the ARP, PTP and NMAC host-control frame sources onto the single
// 9-bit stream feeding the frame encapsulator. One source is granted at a time,
// its frame is forwarded with one register of latency, and its descriptor is
// latched at grant and held until the next grant (the encapsulator reads it
// well after SOF). An inter-frame gap follows every completed frame.
// Ports:
//   i_clk, i_rst_n   - clock, asynchronous active-low reset
//   iv_req           - per-source request
//   ov_grant         - one-hot grant
//   iv_data          - per-source beats, source k at [9k+8:9k], bit 8 = SOF/EOF
//   iv_data_wr       - per-source beat valid
//   iv_descriptor    - per-source descriptor, source k at [35k+34:35k]
//   ov_data          - forwarded beat
//   o_data_wr        - forwarded beat valid
//   ov_descriptor    - descriptor of the current/last granted frame
//   o_busy           - arbiter not idle
//   o_start_timeout  - pulse when a grant is revoked for lack of SOF
//   o_wr_gap_err     - pulse (once per frame) when valid drops mid-frame
module encap_src_arbiter
    import encap_arb_pkg::*;
#(
    parameter int unsigned IFG_CYCLES    = IFG_CYCLES_DEF,
    parameter int unsigned START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_SRC-1:0]         iv_req,
    output logic [NUM_SRC-1:0]         ov_grant,
    input  logic [NUM_SRC*BEAT_W-1:0]  iv_data,
    input  logic [NUM_SRC-1:0]         iv_data_wr,
    input  logic [NUM_SRC*DESC_W-1:0]  iv_descriptor,
    output logic [BEAT_W-1:0]          ov_data,
    output logic                       o_data_wr,
    output logic [DESC_W-1:0]          ov_descriptor,
    output logic                       o_busy,
    output logic                       o_start_timeout,
    output logic                       o_wr_gap_err
);

    localparam int unsigned TmoW = $clog2(START_TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(IFG_CYCLES + 1);

    arb_state_e          state_q, state_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [DESC_W-1:0]   desc_q, desc_d;
    logic                rr_q, rr_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [BEAT_W-1:0]   data_q, data_d;
    logic                wr_q, wr_d;
    logic                tmo_pulse_q, tmo_pulse_d;
    logic                gerr_q, gerr_d;
    logic                gerr_seen_q, gerr_seen_d;

    logic [NUM_SRC-1:0]  pick;
    logic [DESC_W-1:0]   pick_desc;
    logic [BEAT_W-1:0]   sel_data;
    logic                sel_wr;
    logic                sel_req;
    logic                sof_eof;

    encap_arb_pick u_pick (
        .iv_req   (iv_req),
        .i_rr_ptr (rr_q),
        .ov_pick  (pick)
    );

    // AND-OR muxes: descriptor by the fresh pick, beat by the held grant
    always_comb begin
        pick_desc = '0;
        sel_data  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            pick_desc = pick_desc | (iv_descriptor[k*DESC_W +: DESC_W] & {DESC_W{pick[k]}});
            sel_data  = sel_data  | (iv_data[k*BEAT_W +: BEAT_W] & {BEAT_W{grant_q[k]}});
        end
    end

    assign sel_wr  = |(iv_data_wr & grant_q);
    assign sel_req = |(iv_req & grant_q);
    assign sof_eof = sel_data[BEAT_W-1];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        desc_d      = desc_q;
        rr_d        = rr_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        data_d      = data_q;
        wr_d        = 1'b0;
        tmo_pulse_d = 1'b0;
        gerr_d      = 1'b0;
        gerr_seen_d = gerr_seen_q;

        unique case (state_q)
            StIdle: begin
                if (|pick) begin
                    grant_d = pick;
                    desc_d  = pick_desc;
                    tmo_d   = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (sel_wr && sof_eof) begin
                    wr_d        = 1'b1;
                    data_d      = sel_data;
                    gerr_seen_d = 1'b0;
                    state_d     = StXfer;
                end else if (!sel_req) begin
                    grant_d = '0;
                    state_d = StIdle;
                    if (!grant_q[SRC_PTP]) rr_d = ~rr_q;
                end else if (tmo_q == TmoW'(START_TIMEOUT - 1)) begin
                    // The source has now had START_TIMEOUT sampled cycles for SOF
                    tmo_pulse_d = 1'b1;
                    grant_d     = '0;
                    state_d     = StIdle;
                    if (!grant_q[SRC_PTP]) rr_d = ~rr_q;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StXfer: begin
                if (sel_wr) begin
                    wr_d   = 1'b1;
                    data_d = sel_data;
                    if (sof_eof) begin
                        grant_d = '0;
                        gap_d   = GapW'(IFG_CYCLES);
                        state_d = StGap;
                        if (!grant_q[SRC_PTP]) rr_d = ~rr_q;
                    end
                end else if (!gerr_seen_q) begin
                    gerr_d      = 1'b1;
                    gerr_seen_d = 1'b1;
                end
            end
            StGap: begin
                if (gap_q <= GapW'(1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            desc_q      <= '0;
            rr_q        <= 1'b0;
            tmo_q       <= '0;
            gap_q       <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            tmo_pulse_q <= 1'b0;
            gerr_q      <= 1'b0;
            gerr_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            desc_q      <= desc_d;
            rr_q        <= rr_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            tmo_pulse_q <= tmo_pulse_d;
            gerr_q      <= gerr_d;
            gerr_seen_q <= gerr_seen_d;
        end
    end

    assign ov_grant        = grant_q;
    assign ov_descriptor   = desc_q;
    assign ov_data         = data_q;
    assign o_data_wr       = wr_q;
    assign o_start_timeout = tmo_pulse_q;
    assign o_wr_gap_err    = gerr_q;
    assign o_busy          = (state_q != StIdle);

endmodule

// File: tb/tb_encap_src_arbiter.sv
module tb_encap_src_arbiter;
    import encap_arb_pkg::*;

    localparam int IFG = 20;
    localparam int STO = 15;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        req_s [3];
    logic        wr_s [3];
    logic [8:0]  dat_s [3];
    logic [34:0] desc_s [3];

    logic [2:0]   iv_req, iv_data_wr, ov_grant;
    logic [26:0]  iv_data;
    logic [104:0] iv_descriptor;
    logic [8:0]   ov_data;
    logic [34:0]  ov_descriptor;
    logic         o_data_wr, o_busy, o_start_timeout, o_wr_gap_err;

    assign iv_req        = {req_s[2], req_s[1], req_s[0]};
    assign iv_data_wr    = {wr_s[2], wr_s[1], wr_s[0]};
    assign iv_data       = {dat_s[2], dat_s[1], dat_s[0]};
    assign iv_descriptor = {desc_s[2], desc_s[1], desc_s[0]};

    encap_src_arbiter #(
        .IFG_CYCLES    (IFG),
        .START_TIMEOUT (STO)
    ) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .iv_req          (iv_req),
        .ov_grant        (ov_grant),
        .iv_data         (iv_data),
        .iv_data_wr      (iv_data_wr),
        .iv_descriptor   (iv_descriptor),
        .ov_data         (ov_data),
        .o_data_wr       (o_data_wr),
        .ov_descriptor   (ov_descriptor),
        .o_busy          (o_busy),
        .o_start_timeout (o_start_timeout),
        .o_wr_gap_err    (o_wr_gap_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner = granted source or -1; started = SOF seen; gap = idle cycles left
    int          m_owner = -1;
    bit          m_started = 0;
    int          m_wait = 0;
    int          m_gap = 0;
    bit          m_rr_nmac = 0;
    bit          m_err_done = 0;
    logic [2:0]  e_grant = '0;
    logic [34:0] e_desc = '0;
    logic [8:0]  e_data = '0;
    logic        e_wr = 0, e_to = 0, e_ge = 0;

    task automatic m_reset();
        m_owner = -1; m_started = 0; m_wait = 0; m_gap = 0; m_rr_nmac = 0; m_err_done = 0;
        e_grant = '0; e_desc = '0; e_data = '0; e_wr = 0; e_to = 0; e_ge = 0;
    endtask

    task automatic m_release(input int gap);
        if (m_owner != 1) m_rr_nmac = !m_rr_nmac;
        m_owner = -1;
        e_grant = '0;
        m_gap   = gap;
    endtask

    task automatic m_step();
        int p;
        logic w;
        logic [8:0] d;
        e_wr = 0; e_to = 0; e_ge = 0;
        if (m_owner < 0) begin
            if (m_gap > 0) begin
                m_gap--;
            end else begin
                p = -1;
                if (iv_req[1]) p = 1;
                else if (iv_req[0] && iv_req[2]) p = m_rr_nmac ? 2 : 0;
                else if (iv_req[0]) p = 0;
                else if (iv_req[2]) p = 2;
                if (p >= 0) begin
                    m_owner = p; m_started = 0; m_wait = 0;
                    e_grant = 3'(1 << p);
                    e_desc  = desc_s[p];
                end
            end
        end else begin
            w = wr_s[m_owner];
            d = dat_s[m_owner];
            if (!m_started) begin
                if (w && d[8]) begin
                    e_wr = 1; e_data = d; m_started = 1; m_err_done = 0;
                end else if (!req_s[m_owner]) begin
                    m_release(0);
                end else begin
                    m_wait++;
                    if (m_wait == STO) begin
                        e_to = 1;
                        m_release(0);
                    end
                end
            end else begin
                if (w) begin
                    e_wr = 1; e_data = d;
                    if (d[8]) m_release(IFG);
                end else if (!m_err_done) begin
                    e_ge = 1; m_err_done = 1;
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge i_clk or negedge i_rst_n);
            if (!i_rst_n) m_reset();
            else m_step();
        end
    end

    // ---------------- compare + monitor ----------------
    int cyc = 0;
    int mon_beats = 0, mon_ge = 0, mon_to = 0, mon_wrlow = 0;
    bit mon_in_frame = 0, mon_have_eof = 0;
    int mon_last_eof = 0;
    int q_order[$];
    int q_gaps[$];
    logic [2:0] prev_grant = '0;

    initial begin
        forever begin
            @(negedge i_clk);
            cyc++;
            if (chk_en) begin
                chk("grant", 64'(ov_grant), 64'(e_grant));
                chk("descriptor", 64'(ov_descriptor), 64'(e_desc));
                chk("data_wr", 64'(o_data_wr), 64'(e_wr));
                if (e_wr) chk("data", 64'(ov_data), 64'(e_data));
                chk("start_timeout", 64'(o_start_timeout), 64'(e_to));
                chk("wr_gap_err", 64'(o_wr_gap_err), 64'(e_ge));
                chk("busy", 64'(o_busy), 64'((m_owner >= 0) || (m_gap > 0)));
                if (!i_rst_n) begin
                    mon_in_frame = 0; mon_have_eof = 0;
                end else begin
                    if (prev_grant == 3'b000 && ov_grant != 3'b000) begin
                        for (int k = 0; k < 3; k++) if (ov_grant[k]) q_order.push_back(k);
                    end
                    if (o_data_wr) mon_beats++;
                    if (o_wr_gap_err) mon_ge++;
                    if (o_start_timeout) mon_to++;
                    if (mon_in_frame && !o_data_wr) mon_wrlow++;
                    if (o_data_wr && ov_data[8]) begin
                        if (!mon_in_frame) begin
                            if (mon_have_eof) q_gaps.push_back(cyc - mon_last_eof);
                            mon_in_frame = 1;
                        end else begin
                            mon_in_frame = 0; mon_have_eof = 1; mon_last_eof = cyc;
                        end
                    end
                end
                prev_grant = ov_grant;
            end
        end
    end

    // ---------------- source drivers ----------------
    task automatic src_frame(input int s, input int nb, input int junk, input int gap_at,
                             input int gap_len, input logic [34:0] desc, output int waited);
        desc_s[s] = desc;
        req_s[s]  = 1'b1;
        waited    = 0;
        do begin
            @(negedge i_clk);
            waited++;
        end while (!ov_grant[s] && waited < 400);
        if (!ov_grant[s]) begin
            total++; bad++;
            $display("FAIL grant_wait src=%0d: grant=%b never set", s, ov_grant);
            req_s[s] = 1'b0;
            return;
        end
        for (int j = 0; j < junk; j++) begin
            wr_s[s] = 1'b1; dat_s[s] = {1'b0, 8'(8'hA0 + j)};
            @(negedge i_clk);
        end
        for (int b = 0; b < nb; b++) begin
            if (b == gap_at) begin
                wr_s[s] = 1'b0;
                repeat (gap_len) @(negedge i_clk);
            end
            wr_s[s]  = 1'b1;
            dat_s[s] = {(b == 0 || b == nb - 1), 8'(s * 40 + b)};
            @(negedge i_clk);
        end
        wr_s[s] = 1'b0; req_s[s] = 1'b0; dat_s[s] = '0;
    endtask

    task automatic noise(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            wr_s[s]  = ~wr_s[s];
            dat_s[s] = {1'b1, 8'($urandom)};
            @(negedge i_clk);
        end
        wr_s[s] = 1'b0; dat_s[s] = '0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (o_busy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        chk(nm, 64'(o_busy), 64'd0);
        repeat (2) @(negedge i_clk);
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit hit");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n, t0;
        for (int k = 0; k < 3; k++) begin
            req_s[k] = 0; wr_s[k] = 0; dat_s[k] = '0; desc_s[k] = '0;
        end
        #1 i_rst_n = 1'b0;
        #1 chk_en = 1;
        #1;
        chk("rst_grant", 64'(ov_grant), 64'd0);
        chk("rst_data_wr", 64'(o_data_wr), 64'd0);
        chk("rst_desc", 64'(ov_descriptor), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Single ARP frame
        mon_beats = 0;
        src_frame(0, 4, 0, -1, 0, 35'h3_1234_0806, w);
        chk("arp_grant_latency", 64'(w), 64'd1);
        @(negedge i_clk);
        chk("arp_beats", 64'(mon_beats), 64'd4);
        chk("arp_grant_drop", 64'(ov_grant), 64'd0);
        chk("arp_desc", 64'(ov_descriptor[15:0]), 64'h0806);
        wait_idle("arp_idle");
        chk("arp_desc_hold", 64'(ov_descriptor), 64'h3_1234_0806);

        // Contention: PTP first, then ARP/NMAC alternation
        do_reset();
        q_order.delete(); q_gaps.delete();
        fork
            src_frame(1, 5, 0, -1, 0, 35'h1_0000_88F7, w);
            begin
                int wa;
                repeat (3) src_frame(0, 4, 0, -1, 0, 35'h0_0000_0806, wa);
            end
            begin
                int wn;
                repeat (2) src_frame(2, 6, 0, -1, 0, 35'h2_0000_4E4D, wn);
            end
        join
        wait_idle("cont_idle");
        chk("cont_frames", 64'(q_order.size()), 64'd6);
        if (q_order.size() == 6) begin
            chk("cont_order0", 64'(q_order[0]), 64'd1);
            chk("cont_order1", 64'(q_order[1]), 64'd0);
            chk("cont_order2", 64'(q_order[2]), 64'd2);
            chk("cont_order3", 64'(q_order[3]), 64'd0);
            chk("cont_order4", 64'(q_order[4]), 64'd2);
            chk("cont_order5", 64'(q_order[5]), 64'd0);
        end
        chk("cont_gap_count", 64'(q_gaps.size()), 64'd5);
        foreach (q_gaps[i]) chk("cont_ifg_ge_22", 64'(q_gaps[i] >= IFG + 2), 64'd1);

        // Start timeout on NMAC (round-robin pointer is at NMAC here)
        mon_to = 0;
        desc_s[2] = 35'h2_DEAD_0001;
        req_s[2]  = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!ov_grant[2] && n < 50);
        chk("tmo_grant", 64'(ov_grant), 64'b100);
        t0 = 0;
        while (!o_start_timeout && t0 < 40) begin
            @(negedge i_clk);
            t0++;
        end
        req_s[2] = 1'b0;
        chk("tmo_latency", 64'(t0), 64'(STO));
        chk("tmo_grant_clear", 64'(ov_grant), 64'd0);
        chk("tmo_back_idle", 64'(o_busy), 64'd0);
        repeat (3) @(negedge i_clk);
        chk("tmo_pulse_count", 64'(mon_to), 64'd1);

        // Pointer moved to ARP: simultaneous ARP/NMAC requests serve ARP first
        q_order.delete();
        fork
            begin
                int wa;
                src_frame(0, 3, 0, -1, 0, 35'h0_0000_0A0A, wa);
            end
            begin
                int wn;
                src_frame(2, 3, 0, -1, 0, 35'h2_0000_0B0B, wn);
            end
        join
        wait_idle("rr_idle");
        chk("rr_after_tmo_first", 64'(q_order.size() > 0 ? q_order[0] : -1), 64'd0);

        // Mid-frame wr drop on PTP
        mon_ge = 0; mon_beats = 0; mon_wrlow = 0;
        src_frame(1, 10, 0, 5, 2, 35'h1_0000_0077, w);
        @(negedge i_clk);
        chk("gap_err_pulses", 64'(mon_ge), 64'd1);
        chk("gap_err_beats", 64'(mon_beats), 64'd10);
        chk("gap_err_wr_low", 64'(mon_wrlow), 64'd2);
        wait_idle("gap_err_idle");

        // Noise: ARP toggles wr with bit8 set, NMAC sends pre-SOF junk
        mon_beats = 0;
        fork
            begin
                int wn;
                src_frame(2, 6, 2, -1, 0, 35'h2_0000_5151, wn);
            end
            noise(0, 20);
        join
        @(negedge i_clk);
        chk("noise_beats", 64'(mon_beats), 64'd6);
        wait_idle("noise_idle");

        // Asynchronous reset during beat 10 of an ARP frame
        desc_s[0] = 35'h0_0000_1111;
        req_s[0]  = 1'b1;
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!ov_grant[0] && n < 50);
        for (int b = 0; b <= 10; b++) begin
            wr_s[0] = 1'b1; dat_s[0] = {(b == 0), 8'(b)};
            if (b < 10) @(negedge i_clk);
        end
        #2;
        i_rst_n   = 1'b0;
        desc_s[2] = 35'h2_0000_2222;
        req_s[2]  = 1'b1;
        req_s[0]  = 1'b0; wr_s[0] = 1'b0; dat_s[0] = '0;
        #1;
        chk("rst_mid_grant", 64'(ov_grant), 64'd0);
        chk("rst_mid_data_wr", 64'(o_data_wr), 64'd0);
        chk("rst_mid_data", 64'(ov_data), 64'd0);
        chk("rst_mid_desc", 64'(ov_descriptor), 64'd0);
        chk("rst_mid_busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        src_frame(2, 4, 0, -1, 0, 35'h2_0000_2222, w);
        chk("post_rst_grant_latency", 64'(w), 64'd1);
        wait_idle("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
